// File: rtl/isa_pkg.sv
// Shared constants and types for the instruction-memory loader slice.
//   DW    : instruction / byte width
//   DEPTH : number of instruction words
//   AW    : word address width (AW must equal log2(DEPTH))
//   ld_state_e : loader FSM states. CHK is only reachable when the build
//                defines INSTR_LOADER_CHECKSUM_EN.
package isa_pkg;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DW instruction store.
//   clk, rst_n : clock, asynchronous active-low clear of every entry
//   we, waddr, wdata : one synchronous write port
//   raddr, rdata     : one combinational read port (fetch path)
module instr_mem_array #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DEPTH-1:0][DW-1:0] mem;

  // Reset wipes the whole array so an abandoned load leaves no partial program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Runtime program loader for the single-cycle instruction memory.
// Accepts a byte stream over Byte_Valid/Byte_Ready, writes it from entry 0
// upward, and holds the CPU (Cpu_Hold) while the load runs.
// Ports:
//   Clk, Reset              : clock, asynchronous active-low reset
//   Load_Start, Load_Len    : start request (IDLE/DONE only), byte count (0 = DEPTH)
//   Byte_In, Byte_Valid     : stream in; Byte_Ready = loader can take a byte
//   PC, Instr_Code          : combinational fetch read, PC wraps modulo DEPTH
//   Cpu_Hold, Load_Done     : load in progress / load finished
//   Load_Err                : checksum mismatch (0 unless checksum build)
// Build option: INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (CHK state) that is compared, not stored.
module instr_mem_loader
  import isa_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load_Start,
  input  logic [AW:0]   Load_Len,
  input  logic [DW-1:0] Byte_In,
  input  logic          Byte_Valid,
  output logic          Byte_Ready,
  input  logic [7:0]    PC,
  output logic [DW-1:0] Instr_Code,
  output logic          Cpu_Hold,
  output logic          Load_Done,
  output logic          Load_Err
);

  ld_state_e     state, state_nxt;
  logic [AW:0]   rem_q;
  logic [AW-1:0] wptr_q;
  logic          start_ok, xfer, mem_we;

  // Upper PC bits are ignored: the fetch address wraps.
  logic unused_pc;
  assign unused_pc = ^PC[7:AW];

  assign start_ok = Load_Start && (state == IDLE || state == DONE);
  assign xfer     = Byte_Valid && Byte_Ready;
  assign mem_we   = xfer && (state == LOAD);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Byte_Ready = 1'b0;
    Cpu_Hold   = 1'b0;
    Load_Done  = 1'b0;
    case (state)
      IDLE: if (Load_Start) state_nxt = LOAD;
      LOAD: begin
        Byte_Ready = 1'b1;
        Cpu_Hold   = 1'b1;
        if (xfer && rem_q == (AW+1)'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK: begin
        Byte_Ready = 1'b1;
        Cpu_Hold   = 1'b1;
        if (xfer) state_nxt = DONE;
      end
`endif
      DONE: begin
        Load_Done = 1'b1;
        if (Load_Start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer and remaining count. Load_Len of 0 encodes a full DEPTH load.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wptr_q <= '0;
      rem_q  <= '0;
    end else if (start_ok) begin
      wptr_q <= '0;
      rem_q  <= (Load_Len == '0) ? (AW+1)'(DEPTH) : Load_Len;
    end else if (mem_we) begin
      wptr_q <= wptr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q;
  logic          err_q;

  // Running XOR over stored bytes; the byte taken in CHK is compared only.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (mem_we) begin
      csum_q <= csum_q ^ Byte_In;
    end else if (xfer && state == CHK) begin
      err_q  <= (Byte_In != csum_q);
    end
  end

  assign Load_Err = err_q;
`else
  assign Load_Err = 1'b0;
`endif

  instr_mem_array #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (Clk),
    .rst_n(Reset),
    .we   (mem_we),
    .waddr(wptr_q),
    .wdata(Byte_In),
    .raddr(PC[AW-1:0]),
    .rdata(Instr_Code)
  );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a transaction-level model (memory image
// plus load phase) is compared against the DUT on every falling edge, and
// literal reads pin the model at key points.
module tb_instr_mem_loader;
  import isa_pkg::*;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          Clk = 1'b0, Reset = 1'b0, Load_Start = 1'b0, Byte_Valid = 1'b0;
  logic [AW:0]   Load_Len = '0;
  logic [DW-1:0] Byte_In = '0;
  logic [7:0]    PC = '0;
  logic          Byte_Ready, Cpu_Hold, Load_Done, Load_Err;
  logic [DW-1:0] Instr_Code;

  instr_mem_loader dut (
    .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Load_Len(Load_Len),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .PC(PC), .Instr_Code(Instr_Code), .Cpu_Hold(Cpu_Hold),
    .Load_Done(Load_Done), .Load_Err(Load_Err)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;

  // Model: memory image, phase 0 idle / 1 data / 2 checksum / 3 done.
  logic [7:0] m_mem [DEPTH];
  int         m_phase, m_rem, m_ptr;
  logic [7:0] m_x;
  logic       m_err;
  bit         cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("instr_code", {24'd0, Instr_Code}, {24'd0, m_mem[PC[2:0]]});
      chk("cpu_hold",   {31'd0, Cpu_Hold},   {31'd0, (m_phase == 1 || m_phase == 2)});
      chk("byte_ready", {31'd0, Byte_Ready}, {31'd0, (m_phase == 1 || m_phase == 2)});
      chk("load_done",  {31'd0, Load_Done},  {31'd0, (m_phase == 3)});
      chk("load_err",   {31'd0, Load_Err},   {31'd0, m_err});
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_phase = 0; m_rem = 0; m_ptr = 0; m_x = 8'h00; m_err = 1'b0;
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic cyc(input bit st, input logic [AW:0] len, input bit v, input logic [7:0] b);
    Load_Start = st; Load_Len = len; Byte_Valid = v; Byte_In = b;
    @(posedge Clk); #1;
    if (st && (m_phase == 0 || m_phase == 3)) begin
      m_phase = 1; m_rem = (len == 0) ? DEPTH : int'(len);
      m_ptr = 0; m_x = 8'h00; m_err = 1'b0;
    end else if (v && m_phase == 1) begin
      m_mem[m_ptr] = b; m_ptr = (m_ptr + 1) % DEPTH; m_x = m_x ^ b; m_rem--;
      if (m_rem == 0) m_phase = CSUM ? 2 : 3;
    end else if (v && m_phase == 2) begin
      m_err = (b != m_x); m_phase = 3;
    end
    Load_Start = 1'b0; Byte_Valid = 1'b0; Byte_In = 8'hEE;
    PC = PC + 8'd1;
  endtask

  task automatic lit(input logic [7:0] pc, input logic [7:0] exp);
    PC = pc; #1;
    chk($sformatf("rd_pc%0d", pc), {24'd0, Instr_Code}, {24'd0, exp});
  endtask

  task automatic send_csum(input logic [7:0] b);
    if (CSUM) cyc(0, 0, 1, b);
  endtask

  logic [7:0] prog8 [8] = '{8'h33, 8'h71, 8'h1C, 8'hC1, 8'h5B, 8'h02, 8'h03, 8'hC1};
  logic [7:0] prog3 [3] = '{8'hAA, 8'hBB, 8'hCC};

  initial begin
    model_reset();
    cmp_en = 1'b1;
    #12;
    // Reset state
    chk("rst_ready", {31'd0, Byte_Ready}, 0);
    chk("rst_hold",  {31'd0, Cpu_Hold},   0);
    chk("rst_done",  {31'd0, Load_Done},  0);
    chk("rst_err",   {31'd0, Load_Err},   0);
    for (int i = 0; i < 8; i++) lit(8'(i), 8'h00);
    @(posedge Clk); #1; Reset = 1'b1; PC = 8'd0;
    cyc(0, 0, 0, 8'h00);

    // Full-depth load (Load_Len=0), back-to-back bytes
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("hold_in_load", {31'd0, Cpu_Hold}, 1);
      cyc(0, 0, 1, prog8[i]);
    end
    send_csum(8'h04);
    chk("done_after8", {31'd0, Load_Done}, 1);
    chk("hold_after8", {31'd0, Cpu_Hold},  0);
    for (int i = 0; i < 8; i++) lit(8'(i), prog8[i]);
    lit(8'd9, 8'h71);
    cyc(0, 0, 0, 8'h00);

    // Load_Len=3 with Byte_Valid toggling
    cyc(1, 3, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 8'h99);
      cyc(0, 0, 1, prog3[i]);
    end
    send_csum(8'hDD);
    chk("done_after3", {31'd0, Load_Done}, 1);
    cyc(0, 0, 1, 8'h77);  // stream byte while DONE: not taken
    lit(8'd0, 8'hAA); lit(8'd1, 8'hBB); lit(8'd2, 8'hCC); lit(8'd3, 8'hC1);

    // Restart from DONE with one byte
    cyc(1, 1, 0, 8'h00);
    chk("done_drops", {31'd0, Load_Done}, 0);
    cyc(0, 0, 1, 8'h5B);
    send_csum(8'h5B);
    chk("done_again", {31'd0, Load_Done}, 1);
    lit(8'd0, 8'h5B); lit(8'd1, 8'hBB);

    // Reset after 4 of 8 bytes; Load_Start mid-load is ignored
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h22);
    cyc(1, 2, 1, 8'h33);
    cyc(0, 0, 1, 8'h44);
    lit(8'd2, 8'h33); lit(8'd3, 8'h44);
    chk("hold_midload", {31'd0, Cpu_Hold}, 1);
    Reset = 1'b0; model_reset(); #1;
    chk("async_hold", {31'd0, Cpu_Hold},   0);
    chk("async_rdy",  {31'd0, Byte_Ready}, 0);
    for (int i = 0; i < 8; i++) lit(8'(i), 8'h00);
    @(posedge Clk); #1; Reset = 1'b1;
    cyc(0, 0, 0, 8'h00);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Good checksum, then bad checksum
    cyc(1, 3, 0, 8'h00);
    cyc(0, 0, 1, 8'h01); cyc(0, 0, 1, 8'h02); cyc(0, 0, 1, 8'h04);
    chk("in_chk_hold", {31'd0, Cpu_Hold}, 1);
    cyc(0, 0, 1, 8'h07);
    chk("csum_ok_err", {31'd0, Load_Err}, 0);
    lit(8'd3, 8'h00);
    cyc(1, 3, 0, 8'h00);
    cyc(0, 0, 1, 8'h01); cyc(0, 0, 1, 8'h02); cyc(0, 0, 1, 8'h04);
    cyc(0, 0, 1, 8'h06);
    chk("csum_bad_err", {31'd0, Load_Err}, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
    chk("err_held", {31'd0, Load_Err}, 1);
    cyc(1, 1, 0, 8'h00);
    chk("err_cleared", {31'd0, Load_Err}, 0);
    cyc(0, 0, 1, 8'h10); cyc(0, 0, 1, 8'h10);
`endif

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
